// File: rtl/stage_writeback_pipe_pkg.sv
// Shared definitions for the registered write-back stage: load-size encodings
// and the default link register index.
package stage_writeback_pipe_pkg;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_FULL = 2'b11
  } ld_size_e;

  localparam int LINK_REG_DEFAULT = 31;

endpackage

// File: rtl/stage_writeback_pipe_if.sv
// MEM/WB boundary bundle: MEM-stage results going in, register-file write port
// coming out. The slave side is the write-back stage itself.
interface stage_writeback_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              i_enable;
  logic              i_flush;
  logic              i_valid;
  logic [DATA_W-1:0] i_output_mem;
  logic [DATA_W-1:0] i_ALU_res;
  logic [ADDR_W-1:0] i_addr_reg_dst;
  logic [DATA_W-1:0] i_pc_to_reg;
  logic              is_RegWrite;
  logic              is_MemtoReg;
  logic              is_select_addr_reg;
  logic              is_write_pc;
  logic [1:0]        is_load_size;
  logic              is_load_unsigned;

  logic [DATA_W-1:0] o_reg_dst;
  logic [ADDR_W-1:0] o_addr_reg_dst;
  logic              os_RegWrite;
  logic              o_valid;

  modport master (
    output i_enable, i_flush, i_valid, i_output_mem, i_ALU_res, i_addr_reg_dst,
           i_pc_to_reg, is_RegWrite, is_MemtoReg, is_select_addr_reg,
           is_write_pc, is_load_size, is_load_unsigned,
    input  o_reg_dst, o_addr_reg_dst, os_RegWrite, o_valid
  );

  modport slave (
    input  i_enable, i_flush, i_valid, i_output_mem, i_ALU_res, i_addr_reg_dst,
           i_pc_to_reg, is_RegWrite, is_MemtoReg, is_select_addr_reg,
           is_write_pc, is_load_size, is_load_unsigned,
    output o_reg_dst, o_addr_reg_dst, os_RegWrite, o_valid
  );
endinterface

// File: rtl/stage_writeback_pipe_load_extend.sv
// Combinational little-endian load lane extraction with sign/zero extension.
module load_extend
  import stage_writeback_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] ext
);
  localparam int SH_W = OFF_W + 3;

  logic [SH_W-1:0]   byte_sh;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] field;
  logic              sign;

  assign byte_sh = {offset, 3'b000};

  // Halves and words drop the misaligned offset bits by masking the bit shift.
  always_comb begin
    shamt = '0;
    mask  = '1;
    field = '0;
    sign  = 1'b0;
    case (ld_size_e'(size))
      LD_BYTE: begin shamt = byte_sh;                 mask = DATA_W'(8'hFF);         end
      LD_HALF: begin shamt = byte_sh & ~SH_W'(15);    mask = DATA_W'(16'hFFFF);      end
      LD_WORD: begin shamt = byte_sh & ~SH_W'(31);    mask = DATA_W'(32'hFFFF_FFFF); end
      default: begin shamt = '0;                      mask = '1;                     end
    endcase
    field = (data >> shamt) & mask;
    sign  = (size != LD_FULL) && !is_unsigned && (|(field & ~(mask >> 1)));
    ext   = field | (sign ? ~mask : '0);
  end
endmodule

// File: rtl/stage_writeback_pipe_mux2to1.sv
// Generic two-input multiplexer shared by the data and address selects.
module MUX2to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? in1 : in0;
endmodule

// File: rtl/stage_writeback_pipe.sv
// Registered MEM/WB stage driving the register-file write port one cycle later.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module stage_writeback_pipe
  import stage_writeback_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  stage_writeback_pipe_if.slave   wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]             o_retire_cnt
`endif
);
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] mem_or_alu;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;

  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic              valid_reg;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .data        (wb.i_output_mem),
    .offset      (wb.i_ALU_res[OFF_W-1:0]),
    .size        (wb.is_load_size),
    .is_unsigned (wb.is_load_unsigned),
    .ext         (load_data)
  );

  MUX2to1 #(.W(DATA_W)) u_mux_mem (
    .in0 (wb.i_ALU_res), .in1 (load_data), .sel (wb.is_MemtoReg), .y (mem_or_alu)
  );

  MUX2to1 #(.W(DATA_W)) u_mux_pc (
    .in0 (mem_or_alu), .in1 (wb.i_pc_to_reg), .sel (wb.is_write_pc), .y (wb_data)
  );

  MUX2to1 #(.W(ADDR_W)) u_mux_addr (
    .in0 (wb.i_addr_reg_dst), .in1 (ADDR_W'(LINK_REG)), .sel (wb.is_select_addr_reg),
    .y   (wb_addr)
  );

  // Register 0 is hard-wired; its writes never reach the register file.
  assign wb_we = wb.is_RegWrite & wb.i_valid & (wb_addr != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset || wb.i_flush) begin
      data_reg  <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else if (wb.i_enable) begin
      data_reg  <= wb_data;
      addr_reg  <= wb_addr;
      we_reg    <= wb_we;
      valid_reg <= wb.i_valid;
    end
  end

  assign wb.o_reg_dst      = data_reg;
  assign wb.o_addr_reg_dst = addr_reg;
  assign wb.os_RegWrite    = we_reg;
  assign wb.o_valid        = valid_reg;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      retire_cnt_reg <= '0;
    end else if (!wb.i_flush && wb.i_enable && wb.i_valid) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign o_retire_cnt = retire_cnt_reg;
`endif
endmodule

// File: tb/tb_stage_writeback_pipe.sv
// Randomised bench for stage_writeback_pipe against a behavioural model, with
// directed literal checks; retire counter checked when WB_RETIRE_CNT_EN is set.
module tb_stage_writeback_pipe;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic started = 1'b0;

  logic [31:0] exp_data;
  logic [4:0]  exp_addr;
  logic        exp_we;
  logic        exp_valid;
  logic [31:0] exp_cnt;
  logic [31:0] dut_cnt;

  always #5 clk = ~clk;

  stage_writeback_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  stage_writeback_pipe #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .wb      (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retire_cnt (dut_cnt)
`endif
  );

`ifndef WB_RETIRE_CNT_EN
  assign dut_cnt = exp_cnt;
`endif

  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int width;
    case (size)
      2'b00:   begin v = (mem >> (8 * off)) & 32'hFF;         width = 8;  end
      2'b01:   begin v = (mem >> (16 * (off / 2))) & 32'hFFFF; width = 16; end
      default: begin v = mem;                                  width = 32; end
    endcase
    if (!uns && width < 32 && v[width-1]) v = v | ~((32'd1 << width) - 32'd1);
    return v;
  endfunction

  function automatic logic [4:0] ref_addr();
    return bus.is_select_addr_reg ? 5'd31 : bus.i_addr_reg_dst;
  endfunction

  function automatic logic [31:0] ref_data();
    if (bus.is_write_pc) return bus.i_pc_to_reg;
    if (bus.is_MemtoReg)
      return ref_load(bus.i_output_mem, bus.i_ALU_res[1:0], bus.is_load_size, bus.is_load_unsigned);
    return bus.i_ALU_res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Behavioural model: what the write port must show after each edge.
  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst) begin
      exp_data <= '0; exp_addr <= '0; exp_we <= 1'b0; exp_valid <= 1'b0; exp_cnt <= '0;
    end else if (bus.i_flush) begin
      exp_data <= '0; exp_addr <= '0; exp_we <= 1'b0; exp_valid <= 1'b0;
    end else if (bus.i_enable) begin
      exp_data  <= ref_data();
      exp_addr  <= ref_addr();
      exp_we    <= bus.is_RegWrite && bus.i_valid && (ref_addr() != 5'd0);
      exp_valid <= bus.i_valid;
      if (bus.i_valid) exp_cnt <= exp_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_data",  bus.o_reg_dst,             exp_data);
      check("cyc_addr",  32'(bus.o_addr_reg_dst),   32'(exp_addr));
      check("cyc_we",    32'(bus.os_RegWrite),      32'(exp_we));
      check("cyc_valid", 32'(bus.o_valid),          32'(exp_valid));
      check("cyc_cnt",   dut_cnt,                   exp_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_load(input logic [31:0] mem, input logic [31:0] alu, input logic [1:0] size,
                          input logic uns, input logic [4:0] dst);
    bus.i_enable = 1'b1; bus.i_flush = 1'b0; bus.i_valid = 1'b1;
    bus.is_RegWrite = 1'b1; bus.is_MemtoReg = 1'b1; bus.is_write_pc = 1'b0;
    bus.is_select_addr_reg = 1'b0;
    bus.i_output_mem = mem; bus.i_ALU_res = alu; bus.is_load_size = size;
    bus.is_load_unsigned = uns; bus.i_addr_reg_dst = dst;
  endtask

  task automatic randomize_inputs();
    bus.i_valid            = 1'($urandom);
    bus.i_output_mem       = $urandom;
    bus.i_ALU_res          = $urandom;
    bus.i_addr_reg_dst     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    bus.i_pc_to_reg        = $urandom;
    bus.is_RegWrite        = 1'($urandom);
    bus.is_MemtoReg        = 1'($urandom);
    bus.is_select_addr_reg = ($urandom_range(0, 5) == 0);
    bus.is_write_pc        = ($urandom_range(0, 5) == 0);
    bus.is_load_size       = 2'($urandom);
    bus.is_load_unsigned   = 1'($urandom);
  endtask

  initial begin
    logic [31:0] cnt_base;
    rst = 1'b0;
    set_load(32'h80FF7F01, 32'h1002, 2'b00, 1'b0, 5'd8);
    bus.i_pc_to_reg = 32'h44;
    tick(); tick();
    check("reset_data", bus.o_reg_dst, 32'h0);
    check("reset_we",   32'(bus.os_RegWrite), 32'h0);
    check("reset_cnt",  dut_cnt, 32'h0);
    rst = 1'b1;

    tick();
    check("lb_off2", bus.o_reg_dst, 32'hFFFF_FFFF);
    check("lb_off2_model", exp_data, 32'hFFFF_FFFF);
    check("lb_addr", 32'(bus.o_addr_reg_dst), 32'd8);
    check("lb_we", 32'(bus.os_RegWrite), 32'd1);
    bus.i_ALU_res = 32'h1001; tick();
    check("lb_off1", bus.o_reg_dst, 32'h0000_007F);
    bus.i_ALU_res = 32'h1003; bus.is_load_unsigned = 1'b1; tick();
    check("lbu_off3", bus.o_reg_dst, 32'h0000_0080);

    set_load(32'h80FF7F01, 32'h1002, 2'b01, 1'b0, 5'd9); tick();
    check("lh_off2", bus.o_reg_dst, 32'hFFFF_80FF);
    check("lh_off2_model", exp_data, 32'hFFFF_80FF);
    bus.i_ALU_res = 32'h1003; tick();
    check("lh_off3", bus.o_reg_dst, 32'hFFFF_80FF);
    bus.is_load_unsigned = 1'b1; tick();
    check("lhu_off3", bus.o_reg_dst, 32'h0000_80FF);

    bus.is_write_pc = 1'b1; bus.is_select_addr_reg = 1'b1;
    bus.i_pc_to_reg = 32'h44; bus.i_addr_reg_dst = 5'd0; tick();
    check("jal_data", bus.o_reg_dst, 32'h44);
    check("jal_addr", 32'(bus.o_addr_reg_dst), 32'd31);
    check("jal_we", 32'(bus.os_RegWrite), 32'd1);

    bus.is_write_pc = 1'b0; bus.is_select_addr_reg = 1'b0; bus.is_MemtoReg = 1'b0;
    bus.i_ALU_res = 32'h55; tick();
    check("r0_we", 32'(bus.os_RegWrite), 32'd0);
    check("r0_valid", 32'(bus.o_valid), 32'd1);

    cnt_base = exp_cnt;
    bus.i_addr_reg_dst = 5'd3; bus.i_flush = 1'b1; tick();
    check("flush_we", 32'(bus.os_RegWrite), 32'd0);
    check("flush_valid", 32'(bus.o_valid), 32'd0);
    check("flush_cnt", dut_cnt, cnt_base);

    bus.i_flush = 1'b0; bus.i_ALU_res = 32'h1234_5678; bus.i_addr_reg_dst = 5'd5; tick();
    for (int k = 0; k < 3; k++) begin
      randomize_inputs(); bus.i_enable = 1'b0; bus.i_flush = 1'b0; tick();
      check("stall_data", bus.o_reg_dst, 32'h1234_5678);
      check("stall_addr", 32'(bus.o_addr_reg_dst), 32'd5);
      check("stall_we", 32'(bus.os_RegWrite), 32'd1);
    end
    check("stall_cnt", dut_cnt, cnt_base + 32'd1);

    set_load(32'hDEAD_BEEF, 32'h10, 2'b10, 1'b0, 5'd7); tick();
    check("lw_data", bus.o_reg_dst, 32'hDEAD_BEEF);
    rst = 1'b0; tick();
    check("rst_inflight_we", 32'(bus.os_RegWrite), 32'd0);
    check("rst_inflight_data", bus.o_reg_dst, 32'd0);
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      rst          = ($urandom_range(0, 63) != 0);
      bus.i_flush  = ($urandom_range(0, 7) == 0);
      bus.i_enable = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stage_writeback_pipe.md
Name: stage_writeback_pipe

Overview:
- Parametrised, registered successor of the combinational write-back stage. Holds the MEM/WB pipeline register and performs load-data lane extraction with sign/zero extension.
- Selects among ALU result, memory data and return PC, and chooses the destination register.
- Drives the register-file write port one cycle after the MEM-stage inputs are presented.
- Supports pipeline enable (debug step/stall) and flush.

Parameters:
DATA_W, 32, datapath width; multiple of 8, minimum 32
ADDR_W, 5, register-address width
LINK_REG, 31, destination index used when is_select_addr_reg=1 (jal/jalr link)
OFF_W, $clog2(DATA_W/8), byte-offset width (derived localparam, not overridable)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous reset, active-low
i_enable  in  1  pipeline advance; 0 holds all registers
i_flush  in  1  bubble insert; registers a NOP
i_valid  in  1  MEM stage carries a real instruction
i_output_mem  in  DATA_W  raw memory read word
i_ALU_res  in  DATA_W  ALU result; low OFF_W bits are the load byte offset
i_addr_reg_dst  in  ADDR_W  decoded destination register
i_pc_to_reg  in  DATA_W  return address for link
is_RegWrite  in  1  instruction writes the register file
is_MemtoReg  in  1  select memory data
is_select_addr_reg  in  1  force destination to LINK_REG
is_write_pc  in  1  write i_pc_to_reg
is_load_size  in  2  00 byte, 01 half, 10 word(32), 11 full DATA_W
is_load_unsigned  in  1  zero-extend instead of sign-extend
o_reg_dst  out  DATA_W  write data
o_addr_reg_dst  out  ADDR_W  write address
os_RegWrite  out  1  write strobe
o_valid  out  1  a real instruction retired this cycle

Behaviour:
- All outputs are registered. Reset (i_reset=0 at a clock edge) clears o_reg_dst, o_addr_reg_dst, os_RegWrite and o_valid to 0. Reset has priority over flush, and flush has priority over enable.
- Latency is 1 clock: inputs sampled at edge N appear on the outputs after edge N.
- i_enable=0 and no flush/reset: every output holds its value. os_RegWrite stays asserted if it was asserted; the register file tolerates the rewrite of identical data.
- i_flush=1 (and no reset): o_valid=0 and os_RegWrite=0. Data and address are cleared to 0. This takes effect regardless of i_enable.
- Load extraction, little-endian, using offset = i_ALU_res[OFF_W-1:0]:
  - byte: lane = offset.
  - half: lane index = offset>>1, so the misaligned low bit is ignored.
  - word: lane index = offset>>2.
  - full: the whole word, no extension.
  - The extracted field is sign-extended to DATA_W, or zero-extended when is_load_unsigned=1.
  - When DATA_W=32, size 11 equals size 10.
- Data select: is_write_pc=1 selects i_pc_to_reg. Otherwise is_MemtoReg=1 selects the extracted load. Otherwise i_ALU_res.
- Address select: is_select_addr_reg=1 selects LINK_REG. Otherwise i_addr_reg_dst.
- Registered write strobe: os_RegWrite = is_RegWrite & i_valid & (selected address != 0). Writes to register 0 are always suppressed; data and address are still registered.
- o_valid = i_valid, registered.
- Reset asserted while a write is in flight: the write is dropped and outputs are zero on the next cycle.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined, adds output o_retire_cnt [31:0], a counter reset to 0 that increments by 1 on every edge where a valid instruction is registered (enable=1, flush=0, i_valid=1). It wraps from 0xFFFFFFFF to 0. It is used by the debug unit for instruction counting.
- When undefined, the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - load-size encodings LD_BYTE=2'b00, LD_HALF=2'b01, LD_WORD=2'b10, LD_FULL=2'b11
  - default LINK_REG
- One sub-module, load_extend: purely combinational. Inputs are raw data, offset, size and unsigned; output is DATA_W extended data. It is parametrised by DATA_W.
- The existing MUX2to1 is reused for the data and address selects.

Test Plan:
- Reset: hold i_reset=0 for 2 clocks with all inputs active -> every output is 0; with WB_RETIRE_CNT_EN defined, o_retire_cnt=0.
- LB signed: mem=0x80FF7F01, ALU_res=0x1002 (offset 2), size=00, unsigned=0, MemtoReg=1, RegWrite=1, dst=8 -> next cycle o_reg_dst=0xFFFFFFFF, o_addr_reg_dst=8, os_RegWrite=1. Same with offset 1 -> 0x0000007F. With offset 3 and unsigned=1 -> 0x00000080.
- LH: mem=0x80FF7F01, offset=2, size=01 -> signed 0xFFFF80FF, unsigned 0x000080FF. Offset 3 gives the same results.
- jal: is_write_pc=1, is_select_addr_reg=1, pc_to_reg=0x00000044, dst=0 -> o_reg_dst=0x44, o_addr_reg_dst=31, os_RegWrite=1.
- r0 suppression and flush:
  - dst=0 with RegWrite=1 -> os_RegWrite=0.
  - i_flush=1 with a valid write -> os_RegWrite=0 and o_valid=0.
  - With WB_RETIRE_CNT_EN defined, the counter does not increment on flushed cycles.
- Stall: load ALU result 0x12345678 to dst 5, then i_enable=0 for 3 cycles while the inputs change -> outputs hold 0x12345678/5/1. The retire counter increments once only.
